sync_edge_event: RTL

Same-clock-domain consumer of the two-flop synchronizer output. Glitch-filters the synchronized level, detects qualified edges, and queues them as a counted backlog drained through a valid/ready handshake. An optional 16-bit event counter supports debug and statistics. Sits directly downstream of the synchronizer, in the `clk_dst` domain.

---
 rtl/sync_pkg.sv | 16 +
 rtl/sync_glitch_filter.sv | 66 ++++++
 rtl/sync_edge_event.sv | 93 +++++++++
 3 files changed

// File: rtl/sync_pkg.sv
// Shared definitions for the synchronizer edge-event path: edge-select encodings,
// glitch-filter state encoding and the event-counter width.
package sync_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    localparam int EVT_CNT_W = 16;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_QUAL   = 1'b1
    } filt_state_e;

endpackage

// File: rtl/sync_glitch_filter.sv
// Glitch filter for a synchronized level: a new level is accepted only after FILT_LEN
// consecutive differing samples; emits single-cycle rise/fall pulses on the toggle edge.
module sync_glitch_filter
    import sync_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic clk_dst,
    input  logic rst_dst,
    input  logic q_sync,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] LEN = 8'(FILT_LEN);

    filt_state_e state;
    filt_state_e state_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [7:0]  cnt_inc;
    logic        diff;
    logic        toggle;

    // A differing sample that would bring the count to FILT_LEN toggles at once, so
    // FILT_LEN = 1 never lingers in QUAL.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        toggle    = 1'b0;
        diff      = (q_sync != level);
        cnt_inc   = (state == ST_QUAL) ? cnt + 8'd1 : 8'd1;
        if (diff) begin
            if (cnt_inc == LEN) begin
                toggle    = 1'b1;
                state_nxt = ST_STABLE;
                cnt_nxt   = 8'd0;
            end else begin
                state_nxt = ST_QUAL;
                cnt_nxt   = cnt_inc;
            end
        end else begin
            state_nxt = ST_STABLE;
            cnt_nxt   = 8'd0;
        end
    end

    always_ff @(posedge clk_dst or posedge rst_dst) begin
        if (rst_dst) begin
            state <= ST_STABLE;
            cnt   <= 8'd0;
            level <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (toggle) begin
                level <= ~level;
            end
        end
    end

    assign rise = toggle & ~level;
    assign fall = toggle &  level;

endmodule

// File: rtl/sync_edge_event.sv
// Edge-event queue behind the synchronizer: filtered edges become a counted backlog
// drained by valid/ready. Optional event counter enabled by SYNC_EDGE_EVT_CNT_EN.
module sync_edge_event
    import sync_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter int PEND_W   = 3,
    parameter int EDGE_SEL = EDGE_BOTH
) (
    input  logic              clk_dst,
    input  logic              rst_dst,
    input  logic              q_sync,
    output logic              level_o,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [PEND_W-1:0] pend_o,
    output logic              ovf_o,
    input  logic              clr_ovf
`ifdef SYNC_EDGE_EVT_CNT_EN
    ,
    output logic [EVT_CNT_W-1:0] evt_count
`endif
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = 1;

    logic rise;
    logic fall;
    logic push;
    logic pop;
    logic full;

    sync_glitch_filter #(
        .FILT_LEN(FILT_LEN)
    ) u_filter (
        .clk_dst(clk_dst),
        .rst_dst(rst_dst),
        .q_sync (q_sync),
        .level  (level_o),
        .rise   (rise),
        .fall   (fall)
    );

    always_comb begin
        push = 1'b0;
        case (EDGE_SEL)
            EDGE_RISE: push = rise;
            EDGE_FALL: push = fall;
            default:   push = rise | fall;
        endcase
    end

    assign evt_valid = (pend_o != '0);
    assign pop       = evt_valid & evt_ready;
    assign full      = (pend_o == PEND_MAX);

    // Simultaneous push and pop cancel, which also lets a full backlog accept an edge.
    always_ff @(posedge clk_dst or posedge rst_dst) begin
        if (rst_dst) begin
            pend_o <= '0;
        end else if (push && !pop && !full) begin
            pend_o <= pend_o + PEND_ONE;
        end else if (pop && !push) begin
            pend_o <= pend_o - PEND_ONE;
        end
    end

    always_ff @(posedge clk_dst or posedge rst_dst) begin
        if (rst_dst) begin
            ovf_o <= 1'b0;
        end else if (push && full && !pop) begin
            ovf_o <= 1'b1;
        end else if (clr_ovf) begin
            ovf_o <= 1'b0;
        end
    end

`ifdef SYNC_EDGE_EVT_CNT_EN
    logic accept;

    assign accept = push & (~full | pop);

    always_ff @(posedge clk_dst or posedge rst_dst) begin
        if (rst_dst) begin
            evt_count <= '0;
        end else if (accept) begin
            evt_count <= evt_count + 16'd1;
        end
    end
`endif

endmodule
